key_device: RTL and testbench

KEY_DEVICE -- requirements
Module: key_device

---
 rtl/key_device_pkg.sv | 46 ++++
 rtl/key_device_debouncer.sv | 72 +++++++
 rtl/key_device.sv | 131 +++++++++++++
 tb/tb_key_device.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_device_pkg.sv
// ---------------------------------------------------------------------------
// key_device_pkg
//   Shared IO-address map for the memory-mapped board peripherals (HEX
//   displays, red LEDs, slide switches, push keys) plus the KCTRL register
//   layout and the default key debounce threshold.
//
//   No ports: imported with `import key_device_pkg::*;`.
// ---------------------------------------------------------------------------
package key_device_pkg;

  // Board peripheral byte addresses
  localparam logic [31:0] HEX_ADDR   = 32'hF0000000;
  localparam logic [31:0] LEDR_ADDR  = 32'hF0000020;
  localparam logic [31:0] SW_ADDR    = 32'hF0000040;
  localparam logic [31:0] KDATA_ADDR = 32'hF0000010;
  localparam logic [31:0] KCTRL_ADDR = 32'hF0000110;

  // Push-key block sizing
  localparam int unsigned NUM_KEYS = 4;

  // Consecutive stable cycles needed before a key change is accepted
  localparam logic [15:0] KEY_DEBOUNCE_DEFAULT = 16'd50000;

  // KCTRL bit positions
  localparam int unsigned KCTRL_READY_BIT   = 0;
  localparam int unsigned KCTRL_OVERRUN_BIT = 1;
  localparam int unsigned KCTRL_IE_BIT      = 4;

  // Architectural KCTRL state
  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } kctrl_t;

  // Pack the KCTRL state into its 32-bit bus view; unused bits read as 0.
  function automatic logic [31:0] kctrl_word(input kctrl_t s);
    logic [31:0] w;
    w                    = '0;
    w[KCTRL_READY_BIT]   = s.ready;
    w[KCTRL_OVERRUN_BIT] = s.overrun;
    w[KCTRL_IE_BIT]      = s.ie;
    return w;
  endfunction

endpackage

// File: rtl/key_device_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//   Single-bit push-key conditioner: two-flop synchronizer (inverting, so a
//   pressed key reads 1) followed by a saturating stability counter. The
//   debounced output only follows the synchronized input after it has
//   differed from the current debounced value for DEBOUNCE_CYCLES
//   consecutive cycles.
//
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   synchronous active-high reset
//     key_n_i   in   raw active-low key, asynchronous to clk
//     deb_o     out  debounced key state, 1 = pressed
//     change_o  out  high in the cycle whose closing edge updates deb_o
// ---------------------------------------------------------------------------
module key_debouncer
  import key_device_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic deb_o,
  output logic change_o
);

  // Counter value at which the pending change is committed. With a
  // threshold of 1 this is 0, so the very first differing cycle commits.
  localparam logic [15:0] LAST_COUNT = DEBOUNCE_CYCLES - 16'd1;

  logic        meta_q;
  logic        sync_q;
  logic        deb_q;
  logic        deb_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= ~key_n_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any cycle where the synchronized value agrees with the debounced one
  // discards the partial count, so only an uninterrupted run commits.
  // The counter clears on commit and therefore never wraps.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_COUNT) begin
      deb_d = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign deb_o    = deb_q;
  assign change_o = deb_d ^ deb_q;

endmodule

// File: rtl/key_device.sv
// ---------------------------------------------------------------------------
// key_device
//   Memory-mapped four-key input peripheral. Each key is synchronized and
//   debounced; the debounced vector is readable at KDATA. KCTRL reports
//   a ready flag (new key state since last KDATA read), an overrun flag
//   (a further change arrived while ready was still pending) and holds
//   the interrupt enable.
//
//   Ports:
//     clk      in   system clock, rising edge
//     reset    in   synchronous active-high reset, beats any bus access
//     addr     in   [31:0] CPU byte address
//     rd_en    in   read strobe, one cycle per access
//     wr_en    in   write strobe, one cycle per access
//     wdata    in   [31:0] write data
//     key_n    in   [3:0] raw active-low keys
//     rdata    out  [31:0] read data, combinational, 0 when not selected
//     sel      out  address hits KDATA or KCTRL (read-mux steering)
//     irq      out  registered interrupt request (ready & ie)
//
//   Register map:
//     KDATA  {28'b0, debounced[3:0]}            writes ignored
//     KCTRL  {27'b0, ie, 2'b0, overrun, ready}  write: ie <= wdata[4],
//            wdata[1]==0 clears overrun, ready bit of the write ignored
// ---------------------------------------------------------------------------
module key_device
  import key_device_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR       = KDATA_ADDR,
  parameter logic [31:0] CTRL_ADDR       = KCTRL_ADDR,
  parameter logic [15:0] DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic [3:0]  key_n,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        irq
);

  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] key_chg;

  kctrl_t status_q;
  kctrl_t status_d;
  logic   irq_q;

  logic hit_data;
  logic hit_ctrl;
  logic rd_kdata;
  logic wr_kctrl;
  logic change_evt;

  // Only bits 4 and 1 of a KCTRL write carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:5], wdata[3:2], wdata[0]};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk      (clk),
      .reset    (reset),
      .key_n_i  (key_n[g]),
      .deb_o    (deb[g]),
      .change_o (key_chg[g])
    );
  end

  // Full 32-bit compares: no partial decoding, no aliases.
  assign hit_data = (addr == DATA_ADDR);
  assign hit_ctrl = (addr == CTRL_ADDR);
  assign sel      = hit_data | hit_ctrl;

  assign rd_kdata   = rd_en & hit_data;
  assign wr_kctrl   = wr_en & hit_ctrl;
  // Several keys settling on the same edge count as a single event.
  assign change_evt = |key_chg;

  always_comb begin
    status_d = status_q;

    if (wr_kctrl) begin
      status_d.ie = wdata[KCTRL_IE_BIT];
      if (!wdata[KCTRL_OVERRUN_BIT]) begin
        status_d.overrun = 1'b0;
      end
    end

    // A change event outranks a coincident KDATA read: the CPU read the
    // old value, so ready must stay set. The read does count as consuming
    // the previous event, so no overrun is flagged in that case. An event
    // overrun also outranks a same-cycle software clear of overrun.
    if (change_evt) begin
      status_d.ready = 1'b1;
      if (status_q.ready && !rd_kdata) begin
        status_d.overrun = 1'b1;
      end
    end else if (rd_kdata) begin
      status_d.ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= status_d.ready & status_d.ie;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (hit_data) begin
        rdata = {{(32-NUM_KEYS){1'b0}}, deb};
      end else if (hit_ctrl) begin
        rdata = kctrl_word(status_q);
      end
    end
  end

endmodule

// File: tb/tb_key_device.sv
module tb_key_device;

  localparam logic [31:0] DATA = 32'hF0000010;
  localparam logic [31:0] CTRL = 32'hF0000110;
  localparam logic [31:0] NONE = 32'hF0000014;
  localparam int          DC   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [3:0]  key_n;
  logic [31:0] rdata;
  logic        sel;
  logic        irq;

  always #5 clk = ~clk;

  key_device #(
    .DATA_ADDR       (DATA),
    .CTRL_ADDR       (CTRL),
    .DEBOUNCE_CYCLES (16'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .wdata (wdata),
    .key_n (key_n),
    .rdata (rdata),
    .sel   (sel),
    .irq   (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model. Keys: the value seen by the debounce logic at an edge
  // is the raw pressed vector sampled two edges earlier; a debounced bit
  // flips once the last DC seen values all disagree with it.
  logic [3:0] m_deb;
  logic       m_rdy, m_ovr, m_ie, m_irq;
  logic [3:0] raw_hist[$];
  logic [3:0] win[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    if (!rd_en) return 32'h0;
    if (addr == DATA) return {28'h0, m_deb};
    if (addr == CTRL) return {27'h0, m_ie, 2'b00, m_ovr, m_rdy};
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [3:0] seen, nd;
    logic       chg, rdk, wrc, rdy, ovr, ie;
    if (reset) begin
      m_deb = '0; m_rdy = 0; m_ovr = 0; m_ie = 0; m_irq = 0;
      raw_hist = '{4'h0, 4'h0};
      win.delete();
      return;
    end
    seen = raw_hist.pop_front();
    raw_hist.push_back(~key_n);
    win.push_back(seen);
    if (win.size() > DC) void'(win.pop_front());
    nd = m_deb;
    if (win.size() == DC) begin
      for (int b = 0; b < 4; b++) begin
        bit all_differ;
        all_differ = 1'b1;
        foreach (win[i]) if (win[i][b] == m_deb[b]) all_differ = 1'b0;
        if (all_differ) nd[b] = ~m_deb[b];
      end
    end
    chg = (nd != m_deb);
    rdk = rd_en && (addr == DATA);
    wrc = wr_en && (addr == CTRL);
    rdy = m_rdy; ovr = m_ovr; ie = m_ie;
    if (wrc) begin
      ie = wdata[4];
      if (!wdata[1]) ovr = 1'b0;
    end
    if (chg) begin
      if (m_rdy && !rdk) ovr = 1'b1;
      rdy = 1'b1;
    end else if (rdk) begin
      rdy = 1'b0;
    end
    m_deb = nd; m_rdy = rdy; m_ovr = ovr; m_ie = ie;
    m_irq = rdy & ie;
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rdata", rdata, exp_rdata());
    chk("sel", {31'h0, sel}, {31'h0, (addr == DATA) || (addr == CTRL)});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  // Zero-time read between edges: no clock edge sees the strobe.
  task automatic peek(input logic [31:0] a, output logic [31:0] d, output logic s);
    rd_en = 1'b1; addr = a;
    #1;
    d = rdata; s = sel;
    rd_en = 1'b0; addr = '0;
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    wr_en = 1'b1; addr = a; wdata = v;
    tick();
    wr_en = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic read_kdata();
    rd_en = 1'b1; addr = DATA;
    tick();
    rd_en = 1'b0; addr = '0;
  endtask

  logic [31:0] d;
  logic        s;
  int          hold;

  initial begin
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; key_n = 4'hF;
    m_deb = '0; m_rdy = 0; m_ovr = 0; m_ie = 0; m_irq = 0;
    raw_hist = '{4'h0, 4'h0};
    @(negedge clk);
    repeat (3) tick();

    // Reset state
    peek(DATA, d, s); chk("rst_kdata", d, 32'h0);
    peek(CTRL, d, s); chk("rst_kctrl", d, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    // Press KEY[2]: visible exactly 2+4 edges later
    key_n = 4'b1011;
    repeat (5) tick();
    peek(DATA, d, s); chk("press_early", d, 32'h0);
    tick();
    peek(DATA, d, s); chk("press_kdata", d, 32'h4);
    peek(CTRL, d, s); chk("press_kctrl", d, 32'h1);
    read_kdata();
    peek(CTRL, d, s); chk("read_clr_ready", d, 32'h0);
    key_n = 4'hF;
    repeat (6) tick();
    peek(DATA, d, s); chk("release_kdata", d, 32'h0);
    read_kdata();

    // Three-cycle glitch is rejected
    key_n = 4'b1110;
    repeat (3) tick();
    key_n = 4'hF;
    repeat (8) tick();
    peek(DATA, d, s); chk("glitch_kdata", d, 32'h0);
    peek(CTRL, d, s); chk("glitch_kctrl", d, 32'h0);

    // Two events without a read -> overrun; enabling ie raises irq
    key_n = 4'b1110;
    repeat (6) tick();
    key_n = 4'hF;
    repeat (6) tick();
    peek(CTRL, d, s); chk("overrun_kctrl", d, 32'h3);
    chk("irq_before_ie", {31'h0, irq}, 32'h0);
    bus_write(CTRL, 32'h10);
    peek(CTRL, d, s); chk("ie_kctrl", d, 32'h11);
    chk("irq_after_ie", {31'h0, irq}, 32'h1);
    read_kdata();
    chk("irq_after_read", {31'h0, irq}, 32'h0);
    peek(CTRL, d, s); chk("ctrl_after_read", d, 32'h10);

    // KDATA read on the very edge that commits a key change
    key_n = 4'b1101;
    repeat (5) tick();
    peek(DATA, d, s); chk("coinc_early", d, 32'h0);
    read_kdata();
    peek(CTRL, d, s); chk("coinc_kctrl", d, 32'h11);
    peek(DATA, d, s); chk("coinc_kdata", d, 32'h2);
    bus_write(CTRL, 32'h0);
    key_n = 4'hF;
    repeat (6) tick();
    read_kdata();

    // Reset mid-debounce (KEY[0] count 2) racing a KCTRL write
    key_n = 4'b1110;
    repeat (4) tick();
    reset = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr = CTRL; wdata = 32'h12;
    tick();
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    peek(DATA, d, s); chk("midrst_kdata", d, 32'h0);
    peek(CTRL, d, s); chk("midrst_kctrl", d, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    repeat (5) tick();
    peek(DATA, d, s); chk("redeb_early", d, 32'h0);
    tick();
    peek(DATA, d, s); chk("redeb_kdata", d, 32'h1);
    peek(CTRL, d, s); chk("redeb_kctrl", d, 32'h1);

    // Address decode and ignored KDATA write
    peek(NONE, d, s);
    chk("none_rdata", d, 32'h0);
    chk("none_sel", {31'h0, s}, 32'h0);
    peek(DATA, d, s); chk("data_sel", {31'h0, s}, 32'h1);
    peek(CTRL, d, s); chk("ctrl_sel", {31'h0, s}, 32'h1);
    addr = DATA; #1;
    chk("no_rd_rdata", rdata, 32'h0);
    addr = '0; #1;
    bus_write(DATA, 32'hF);
    peek(DATA, d, s); chk("wr_kdata_kdata", d, 32'h1);
    peek(CTRL, d, s); chk("wr_kdata_kctrl", d, 32'h1);

    // Randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        key_n = 4'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      rd_en = ($urandom_range(0, 3) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: addr = DATA;
        1: addr = CTRL;
        2: addr = NONE;
        default: addr = $urandom;
      endcase
      wdata = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
